// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - Default address / data widths of the CPU data port.
//   - Responder FSM state encodings.
//   - Byte-lane count of a data word and width of the wait-state counter.
package data_mem_responder_pkg;

    localparam int DMR_ADDR_LEN = 32;
    localparam int DMR_DATA_LEN = 32;
    localparam int DMR_LANES    = 4;
    localparam int DMR_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmr_state_t;

endpackage

// File: rtl/data_mem_responder_mem_byte_merge.sv
// Byte-lane merge for stores: every lane whose enable bit is set takes the
// new byte, every other lane keeps the old byte (lane i = bits 8i+7:8i).
// Ports:
//   old_word    word currently held in storage
//   new_word    store data
//   be          per-lane byte enables
//   merged_word resulting word to write back
module mem_byte_merge
    import data_mem_responder_pkg::*;
(
    input  logic [DMR_DATA_LEN-1:0] old_word,
    input  logic [DMR_DATA_LEN-1:0] new_word,
    input  logic [DMR_LANES-1:0]    be,
    output logic [DMR_DATA_LEN-1:0] merged_word
);

    genvar gi;
    generate
        for (gi = 0; gi < DMR_LANES; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the multi-cycle CPU data port. Accepts one
// load/store at a time, waits a configurable number of cycles, performs a
// byte-enabled word access on internal storage, and holds the response until
// the requester takes it.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid / req_ready     request handshake
//   req_write                 1 = store, 0 = load
//   req_addr                  byte address
//   req_be                    store byte enables (lane i = bits 8i+7:8i)
//   req_wdata                 store data
//   resp_valid / resp_ready   response handshake
//   resp_rdata                load data (0 for stores and errors)
//   resp_err                  misaligned or out-of-range access
//   busy                      transaction in flight
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_LEN    = DMR_ADDR_LEN,
    parameter int DATA_LEN    = DMR_DATA_LEN,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [3:0]          req_be,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_LEN-1:0] DEPTH_L = ADDR_LEN'(DEPTH_WORDS);

    // WAIT is entered on every acceptance and lasts WAIT_CYCLES+1 cycles; the
    // last of them (counter at 0) is the access cycle. This gives a response
    // WAIT_CYCLES+1 edges after acceptance and keeps the timing identical
    // for WAIT_CYCLES=0.
    localparam logic [DMR_CNT_W-1:0] CNT_LOAD = DMR_CNT_W'(WAIT_CYCLES);

    dmr_state_t           state_reg;
    logic [DMR_CNT_W-1:0] cnt_reg;

    logic                 cap_write_reg;
    logic [ADDR_LEN-1:0]  cap_addr_reg;
    logic [3:0]           cap_be_reg;
    logic [DATA_LEN-1:0]  cap_wdata_reg;

    logic                 req_ready_reg;
    logic                 resp_valid_reg;
    logic [DATA_LEN-1:0]  resp_rdata_reg;
    logic                 resp_err_reg;
    logic                 busy_reg;

    logic [DATA_LEN-1:0]  mem_reg [DEPTH_WORDS];

    logic [ADDR_LEN-3:0]  word_index;
    logic [IDX_W-1:0]     mem_idx;
    logic                 acc_err;
    logic                 do_access;
    logic                 do_store;
    logic [DATA_LEN-1:0]  old_word;
    logic [DATA_LEN-1:0]  merged_word;

    // Range is judged on the full word index so high address bits never alias
    // onto low storage words.
    assign word_index = cap_addr_reg[ADDR_LEN-1:2];
    assign mem_idx    = cap_addr_reg[IDX_W+1:2];
    assign acc_err    = (cap_addr_reg[1:0] != 2'b00) || ({2'b00, word_index} >= DEPTH_L);
    assign do_access  = (state_reg == ST_WAIT) && (cnt_reg == '0);
    assign do_store   = do_access && cap_write_reg && !acc_err;
    assign old_word   = mem_reg[mem_idx];

    mem_byte_merge u_merge (
        .old_word    (old_word),
        .new_word    (cap_wdata_reg),
        .be          (cap_be_reg),
        .merged_word (merged_word)
    );

    // Storage is cleared by reset, so it lives in registers rather than RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_store) begin
            mem_reg[mem_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            cap_write_reg  <= 1'b0;
            cap_addr_reg   <= '0;
            cap_be_reg     <= '0;
            cap_wdata_reg  <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        cap_write_reg <= req_write;
                        cap_addr_reg  <= req_addr;
                        cap_be_reg    <= req_be;
                        cap_wdata_reg <= req_wdata;
                        cnt_reg       <= CNT_LOAD;
                        state_reg     <= ST_WAIT;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= acc_err;
                        resp_rdata_reg <= (!cap_write_reg && !acc_err) ? old_word : '0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_reg      <= ST_IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= '0;
                        resp_err_reg   <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        busy_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance checked
// through a scoreboard fed by an independent storage model, plus a
// WAIT_CYCLES=0 instance for latency and throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_resp_valid, z_resp_ready, z_resp_err, z_busy;
    logic [31:0] z_resp_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [32:0] sb[$];
    logic [31:0] model[int];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    // One transaction on the WAIT_CYCLES=2 instance; hold > 0 withholds
    // resp_ready for that many cycles after the response appears.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int hold);
        logic [32:0] exp_v;
        logic        err;
        int          idx;
        int          k;
        err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
        idx = int'(a >> 2);
        if (err)    exp_v = {1'b1, 32'h0};
        else if (w) begin model[idx] = merge(model_rd(idx), wd, be); exp_v = {1'b0, 32'h0}; end
        else        exp_v = {1'b0, model_rd(idx)};
        sb.push_back(exp_v);

        @(negedge clk);
        chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_be = be; req_wdata = wd;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (resp_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        chk("latency", 64'(k), 64'd3);
        exp_v = sb.pop_front();
        chk("resp", {31'h0, resp_err, resp_rdata}, {31'h0, exp_v});
        last_rdata = resp_rdata;
        $display("txn w=%0d addr=%h be=%h wdata=%h -> err=%0d rdata=%h (exp err=%0d rdata=%h)",
                 w, a, be, wd, resp_err, resp_rdata, exp_v[32], exp_v[31:0]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'h0, resp_valid}, 64'h1);
            chk("hold_data", {31'h0, resp_err, resp_rdata}, {31'h0, exp_v});
            chk("hold_req_ready", {63'h0, req_ready}, 64'h0);
        end
        if (hold > 0) begin @(negedge clk); resp_ready = 1'b1; end
        @(posedge clk); #1;
        chk("idle_valid", {63'h0, resp_valid}, 64'h0);
        chk("idle_req_ready", {63'h0, req_ready}, 64'h1);
        chk("idle_busy", {63'h0, busy}, 64'h0);
    endtask

    // One transaction on the WAIT_CYCLES=0 instance with explicit expectations.
    task automatic txn0(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int k;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_be = be; z_req_wdata = wd;
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        k = 0;
        while (z_resp_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        chk("z_latency", 64'(k), 64'd1);
        chk("z_resp", {31'h0, z_resp_err, z_resp_rdata}, {31'h0, ee, er});
        $display("txn0 w=%0d addr=%h be=%h wdata=%h -> err=%0d rdata=%h (exp err=%0d rdata=%h)",
                 w, a, be, wd, z_resp_err, z_resp_rdata, ee, er);
        @(posedge clk); #1;
        chk("z_idle_req_ready", {63'h0, z_req_ready}, 64'h1);
    endtask

    initial begin
        int acc;
        int rsp;
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_be = 0; req_wdata = 0; resp_ready = 1;
        z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_be = 0; z_req_wdata = 0; z_resp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_rdata_err", {31'h0, resp_err, resp_rdata}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_z_req_ready", {63'h0, z_req_ready}, 64'h1);
        rst = 1'b0;

        // Store abandoned by a reset during WAIT.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 0;
        chk("midwait_busy", {63'h0, busy}, 64'h1);
        chk("midwait_req_ready", {63'h0, req_ready}, 64'h0);
        #2 rst = 1'b1;
        #1;
        chk("midwait_rst_valid", {63'h0, resp_valid}, 64'h0);
        chk("midwait_rst_busy", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;
        chk("midwait_rst_valid2", {63'h0, resp_valid}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        txn(1'b0, 32'h10, 4'h0, 32'h0, 0);
        chk("midwait_not_committed", {32'h0, last_rdata}, 64'h0);

        // Store, partial store, load back.
        txn(1'b1, 32'h04, 4'hF, 32'h12345678, 0);
        txn(1'b1, 32'h04, 4'b0101, 32'hAABBCCDD, 0);
        txn(1'b0, 32'h04, 4'h0, 32'h0, 0);
        chk("merged_word", {32'h0, last_rdata}, {32'h0, 32'h12BB56DD});

        // Error cases.
        txn(1'b0, 32'h06, 4'h0, 32'h0, 0);
        txn(1'b1, 32'h400, 4'hF, 32'h11223344, 0);
        txn(1'b0, 32'h000, 4'h0, 32'h0, 0);
        txn(1'b1, 32'h8000_0000, 4'hF, 32'h55667788, 0);
        txn(1'b0, 32'h000, 4'h0, 32'h0, 0);

        // Response backpressure.
        txn(1'b0, 32'h04, 4'h0, 32'h0, 5);

        // No-op store.
        txn(1'b1, 32'h08, 4'h0, 32'hFFFFFFFF, 0);
        txn(1'b0, 32'h08, 4'h0, 32'h0, 0);
        chk("noop_store", {32'h0, last_rdata}, 64'h0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Zero-wait instance.
        txn0(1'b1, 32'h0C, 4'b1100, 32'hCAFEF00D, 32'h0, 1'b0);
        txn0(1'b0, 32'h0C, 4'h0, 32'h0, 32'hCAFE0000, 1'b0);
        txn0(1'b0, 32'h03, 4'h0, 32'h0, 32'h0, 1'b1);

        // Back-to-back loads with resp_ready high: one per 3 cycles.
        @(negedge clk);
        z_req_valid = 1; z_req_write = 0; z_req_addr = 32'h0C; z_resp_ready = 1;
        acc = 0; rsp = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (z_req_valid && z_req_ready) acc++;
            if (z_resp_valid && z_resp_ready) begin
                rsp++;
                chk("b2b_rdata", {32'h0, z_resp_rdata}, {32'h0, 32'hCAFE0000});
            end
        end
        z_req_valid = 0;
        $display("b2b accepted=%0d responded=%0d in 12 cycles (exp 4/4)", acc, rsp);
        chk("b2b_accepts", 64'(acc), 64'd4);
        chk("b2b_resps", 64'(rsp), 64'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_drain_idle", {63'h0, z_busy}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
